pipelined_ctrl_decoder: RTL and testbench
=========================================

PIPELINED_CTRL_DECODER -- requirements
Module: pipelined_ctrl_decoder

Interface
REQ-001 Parameters SHALL be OPCODE_W, default 5, opcode width (>=5); ALUOP_W, default 5, ALU op field width (>=5); MD_LAT, default 32, mul/div decode hold cycles (>=1).
REQ-002 clock  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 flush  input  1  synchronous pipeline kill.
REQ-005 in_valid  input  1  instruction fields present.
REQ-006 in_ready  output  1  block accepts fields this cycle.
REQ-007 in_opcode  input  OPCODE_W  instruction opcode.
REQ-008 in_aluop  input  ALUOP_W  R-type ALU op field.
REQ-009 out_valid  output  1  registered decode result present.
REQ-010 out_ready  input  1  downstream consumes result.
REQ-011 out_ctrl  output  12  control vector [11]Rwe [10]Rsrc2 [9]ALUinB [8]DMwe [7]Rwd [6]BR [5]JP [4]JAL [3]JR [2]BLT [1]SETX [0]BEX.
REQ-012 out_aluop  output  ALUOP_W  ALU operation for the decoded instruction.
REQ-013 out_illegal  output  1  decoded opcode not in table.
REQ-014 busy  output  1  high in MD_WAIT.

Function
REQ-015 States SHALL be IDLE, MD_WAIT, HOLD; an 8-bit-min down-counter md_cnt (width clog2(MD_LAT)+1).
REQ-016 in_ready SHALL be 1 in IDLE, out_ready in HOLD, 0 in MD_WAIT, and 0 whenever flush=1.
REQ-017 Accept = in_valid & in_ready; on accept, decoded out_ctrl/out_aluop/out_illegal SHALL be registered that edge.
REQ-018 Decode table (set bits only, all others 0): 00000 R Rwe; 00001 j JP; 00010 bne BR,Rsrc2; 00011 jal Rwe,JP,JAL; 00100 jr JR,Rsrc2; 00101 addi Rwe,ALUinB; 00110 blt BR,BLT,Rsrc2; 00111 sw Rsrc2,ALUinB,DMwe; 01000 lw Rwe,ALUinB,Rwd; 10101 setx Rwe,SETX; 10110 bex BEX.
REQ-019 Opcode bits above bit 4 nonzero, or any unlisted code, SHALL give out_ctrl=0, out_aluop=0, out_illegal=1.
REQ-020 out_aluop SHALL be in_aluop for R-type, 00000 for addi/lw/sw, 00001 for bne/blt, 0 otherwise (zero-extended).
REQ-021 Normal accept SHALL go to HOLD; out_valid=1 the next cycle (latency 1).
REQ-022 R-type accept with in_aluop[4:0] = 00110 (mul) or 00111 (div) SHALL go to MD_WAIT, load md_cnt=MD_LAT-1, out_valid=0.
REQ-023 MD_WAIT SHALL decrement md_cnt each cycle; at md_cnt=0 go to HOLD, so out_valid rises exactly MD_LAT cycles after accept.
REQ-024 HOLD with out_ready=1: accept-and-replace if in_valid, else go to IDLE with out_valid=0; with out_ready=0 all outputs SHALL stay stable.
REQ-025 flush SHALL have priority over every event: next state IDLE, out_valid=0, md_cnt=0, outputs cleared to 0, no accept that cycle.
REQ-026 No instruction SHALL be lost or duplicated: each accepted instruction yields exactly one out_valid&out_ready transfer unless flushed.

Reset
REQ-027 reset_n=0 SHALL immediately force IDLE, md_cnt=0, out_valid=0, out_ctrl=0, out_aluop=0, out_illegal=0, busy=0, independent of clock, including mid-MD_WAIT.
REQ-028 First accept SHALL be possible on the first rising edge after reset_n deasserts.

Verification
REQ-029 addi (00101), out_ready=1 -> next cycle out_valid=1, out_ctrl=0xA00, out_aluop=0.
REQ-030 Back-to-back lw, sw, bne with out_ready=1 -> out_ctrl 0xA80, 0x700, 0x440 on consecutive cycles, in_ready held 1.
REQ-031 R-type aluop 00110, MD_LAT=4 -> busy=1 for 4 cycles, in_ready=0, out_valid rises 4 cycles after accept, out_aluop=00110.
REQ-032 HOLD with out_ready=0 for 5 cycles then 1 -> outputs stable, in_ready=0 during stall, single transfer.
REQ-033 Opcode 11111 -> out_illegal=1, out_ctrl=0; flush during MD_WAIT -> IDLE next cycle, out_valid never rises.
REQ-034 reset_n pulsed low mid-MD_WAIT, asynchronous to clock -> outputs 0 immediately, new jal then gives out_ctrl=0x830.

Source files
------------

// File: rtl/pipelined_ctrl_decoder.sv
// Single-slot instruction control decoder: registers the decoded control vector,
// stretches mul/div ops by MD_LAT cycles, and holds the result until consumed.
module pipelined_ctrl_decoder #(
  parameter int OPCODE_W = 5,
  parameter int ALUOP_W  = 5,
  parameter int MD_LAT   = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPCODE_W-1:0] in_opcode,
  input  logic [ALUOP_W-1:0]  in_aluop,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [11:0]         out_ctrl,
  output logic [ALUOP_W-1:0]  out_aluop,
  output logic                out_illegal,
  output logic                busy
);

  localparam int CNT_W = (($clog2(MD_LAT) + 1) > 8) ? ($clog2(MD_LAT) + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MD_WAIT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  typedef struct packed {
    logic [11:0]        ctrl;
    logic [ALUOP_W-1:0] aluop;
    logic               illegal;
    logic               md;
  } dec_t;

  // ctrl bits: Rwe Rsrc2 ALUinB DMwe Rwd BR JP JAL JR BLT SETX BEX
  function automatic dec_t decode(input logic [OPCODE_W-1:0] op,
                                  input logic [ALUOP_W-1:0]  alu);
    dec_t d;
    d = '0;
    if ((op >> 5) != '0) begin
      d.illegal = 1'b1;
    end else begin
      case (op[4:0])
        5'b00000: begin
          d.ctrl  = 12'h800;
          d.aluop = alu;
          d.md    = (alu[4:0] == 5'b00110) || (alu[4:0] == 5'b00111);
        end
        5'b00001: d.ctrl = 12'h020;
        5'b00010: begin d.ctrl = 12'h440; d.aluop = ALUOP_W'(5'd1); end
        5'b00011: d.ctrl = 12'h830;
        5'b00100: d.ctrl = 12'h408;
        5'b00101: d.ctrl = 12'hA00;
        5'b00110: begin d.ctrl = 12'h444; d.aluop = ALUOP_W'(5'd1); end
        5'b00111: d.ctrl = 12'h700;
        5'b01000: d.ctrl = 12'hA80;
        5'b10101: d.ctrl = 12'h802;
        5'b10110: d.ctrl = 12'h001;
        default:  d.illegal = 1'b1;
      endcase
    end
    return d;
  endfunction

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic               valid_r, valid_s;
  logic [11:0]        ctrl_r, ctrl_s;
  logic [ALUOP_W-1:0] aluop_r, aluop_s;
  logic               illegal_r, illegal_s;
  logic               busy_r, busy_s;
  logic               ready_base_s, in_ready_s, accept_s;
  dec_t               dec_s;

  assign dec_s = decode(in_opcode, in_aluop);

  // Input handshake: open when idle or when the held result drains this cycle.
  always_comb begin
    ready_base_s = 1'b0;
    case (state_r)
      IDLE:    ready_base_s = 1'b1;
      HOLD:    ready_base_s = out_ready;
      MD_WAIT: ready_base_s = 1'b0;
      default: ready_base_s = 1'b0;
    endcase
    in_ready_s = ready_base_s & ~flush;
    accept_s   = in_valid & in_ready_s;
  end

  // Next-state and next-output logic; flush outranks accept and countdown.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    valid_s   = valid_r;
    ctrl_s    = ctrl_r;
    aluop_s   = aluop_r;
    illegal_s = illegal_r;
    if (flush) begin
      state_s   = IDLE;
      cnt_s     = '0;
      valid_s   = 1'b0;
      ctrl_s    = 12'h000;
      aluop_s   = '0;
      illegal_s = 1'b0;
    end else if (accept_s) begin
      ctrl_s    = dec_s.ctrl;
      aluop_s   = dec_s.aluop;
      illegal_s = dec_s.illegal;
      if (dec_s.md) begin
        state_s = MD_WAIT;
        cnt_s   = CNT_LOAD;
        valid_s = 1'b0;
      end else begin
        state_s = HOLD;
        cnt_s   = '0;
        valid_s = 1'b1;
      end
    end else begin
      case (state_r)
        IDLE: state_s = IDLE;
        MD_WAIT: begin
          if (cnt_r == '0) begin
            state_s = HOLD;
            valid_s = 1'b1;
          end else begin
            cnt_s = cnt_r - CNT_ONE;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_s = IDLE;
            valid_s = 1'b0;
          end else begin
            state_s = HOLD;
          end
        end
        default: begin
          state_s = IDLE;
          valid_s = 1'b0;
        end
      endcase
    end
    busy_s = (state_s == MD_WAIT);
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      valid_r   <= 1'b0;
      ctrl_r    <= 12'h000;
      aluop_r   <= '0;
      illegal_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      valid_r   <= valid_s;
      ctrl_r    <= ctrl_s;
      aluop_r   <= aluop_s;
      illegal_r <= illegal_s;
      busy_r    <= busy_s;
    end
  end

  assign in_ready    = in_ready_s;
  assign out_valid   = valid_r;
  assign out_ctrl    = ctrl_r;
  assign out_aluop   = aluop_r;
  assign out_illegal = illegal_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_pipelined_ctrl_decoder.sv
// Self-checking bench for pipelined_ctrl_decoder: directed scenarios plus a
// randomized run scored against a queue-based transaction model.
module tb_pipelined_ctrl_decoder;
  localparam int OW  = 6;
  localparam int AW  = 5;
  localparam int LAT = 4;

  localparam logic [11:0] RWE = 12'h800, RSRC2 = 12'h400, ALUINB = 12'h200, DMWE = 12'h100;
  localparam logic [11:0] RWD = 12'h080, BR = 12'h040, JP = 12'h020, JAL = 12'h010;
  localparam logic [11:0] JR = 12'h008, BLT = 12'h004, SETX = 12'h002, BEX = 12'h001;

  logic          clock, reset_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [OW-1:0] in_opcode;
  logic [AW-1:0] in_aluop, out_aluop;
  logic [11:0]   out_ctrl;
  logic          out_illegal, busy;
  int            errors, checks;

  typedef struct {
    logic [11:0] c;
    logic [4:0]  a;
    logic        ill;
    int          ready;
  } exp_t;

  pipelined_ctrl_decoder #(.OPCODE_W(OW), .ALUOP_W(AW), .MD_LAT(LAT)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .in_opcode(in_opcode), .in_aluop(in_aluop),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_aluop(out_aluop), .out_illegal(out_illegal), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instruction table written as mnemonic -> named control bits.
  function automatic void ref_decode(input logic [5:0] op, input logic [4:0] alu,
                                     output logic [11:0] c, output logic [4:0] a,
                                     output logic ill, output logic md);
    c = 12'h000; a = 5'd0; ill = 1'b0; md = 1'b0;
    case (op)
      6'd0:  begin c = RWE; a = alu; md = (alu == 5'd6) || (alu == 5'd7); end
      6'd1:  c = JP;
      6'd2:  begin c = BR | RSRC2; a = 5'd1; end
      6'd3:  c = RWE | JP | JAL;
      6'd4:  c = JR | RSRC2;
      6'd5:  c = RWE | ALUINB;
      6'd6:  begin c = BR | BLT | RSRC2; a = 5'd1; end
      6'd7:  c = RSRC2 | ALUINB | DMWE;
      6'd8:  c = RWE | ALUINB | RWD;
      6'd21: c = RWE | SETX;
      6'd22: c = BEX;
      default: ill = 1'b1;
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] al);
    in_valid = v; in_opcode = op; in_aluop = al;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    checks++; if (out_ctrl !== 12'h000) begin errors++; $display("FAIL rst_ctrl: got %h want 000", out_ctrl); end
    checks++; if (out_aluop !== 5'd0) begin errors++; $display("FAIL rst_aluop: got %h want 0", out_aluop); end
    checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL rst_illegal: got %b want 0", out_illegal); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    reset_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_addi();
    out_ready = 1'b1;
    drive(1'b1, 6'd5, 5'd13);
    tick();
    drive(1'b0, 6'd0, 5'd0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid: got %b want 1", out_valid); end
    checks++; if (out_ctrl !== 12'hA00) begin errors++; $display("FAIL addi_ctrl: got %h want a00", out_ctrl); end
    checks++; if (out_aluop !== 5'd0) begin errors++; $display("FAIL addi_aluop: got %h want 0", out_aluop); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  ops [3];
    logic [11:0] exp_c [3];
    ops = '{6'd8, 6'd7, 6'd2};
    exp_c = '{12'hA80, 12'h700, 12'h440};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ops[i], 5'd3);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_ctrl !== exp_c[i]) begin
        errors++; $display("FAIL b2b_ctrl[%0d]: got v=%b %h want v=1 %h", i, out_valid, out_ctrl, exp_c[i]);
      end
    end
    drive(1'b0, 6'd0, 5'd0);
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_decode_table();
    logic [5:0]  ops [9];
    logic [11:0] exp_c [9];
    logic [4:0]  exp_a [9];
    logic        exp_i [9];
    ops   = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd6, 6'd21, 6'd22, 6'd31, 6'd37};
    exp_c = '{12'h020, 12'h440, 12'h830, 12'h408, 12'h444, 12'h802, 12'h001, 12'h000, 12'h000};
    exp_a = '{5'd0, 5'd1, 5'd0, 5'd0, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0};
    exp_i = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, ops[i], 5'd9);
      tick();
      drive(1'b0, 6'd0, 5'd0);
      checks++; if (out_valid !== 1'b1 || out_ctrl !== exp_c[i] || out_aluop !== exp_a[i] || out_illegal !== exp_i[i]) begin
        errors++;
        $display("FAIL decode op=%0d: got v=%b c=%h a=%h ill=%b want v=1 c=%h a=%h ill=%b",
                 ops[i], out_valid, out_ctrl, out_aluop, out_illegal, exp_c[i], exp_a[i], exp_i[i]);
      end
      tick();
    end
  endtask

  task automatic test_muldiv();
    out_ready = 1'b1;
    drive(1'b1, 6'd0, 5'd6);
    tick();
    drive(1'b0, 6'd0, 5'd0);
    for (int i = 0; i < LAT; i++) begin
      #1;
      checks++; if (busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
        errors++; $display("FAIL md_wait[%0d]: got busy=%b v=%b rdy=%b want 1 0 0", i, busy, out_valid, in_ready);
      end
      tick();
    end
    checks++; if (out_valid !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL md_done: got v=%b busy=%b want 1 0", out_valid, busy);
    end
    checks++; if (out_ctrl !== 12'h800 || out_aluop !== 5'd6) begin
      errors++; $display("FAIL md_data: got c=%h a=%h want 800 06", out_ctrl, out_aluop);
    end
    tick();
  endtask

  task automatic test_stall();
    out_ready = 1'b1;
    drive(1'b1, 6'd4, 5'd0);
    tick();
    drive(1'b1, 6'd1, 5'd0);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (out_valid !== 1'b1 || out_ctrl !== 12'h408 || in_ready !== 1'b0) begin
        errors++; $display("FAIL stall[%0d]: got v=%b c=%h rdy=%b want 1 408 0", i, out_valid, out_ctrl, in_ready);
      end
      tick();
    end
    drive(1'b0, 6'd0, 5'd0);
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_single: got %b want 0", out_valid); end
  endtask

  task automatic test_flush_md();
    out_ready = 1'b1;
    drive(1'b1, 6'd0, 5'd7);
    tick();
    drive(1'b0, 6'd0, 5'd0);
    tick();
    flush = 1'b1;
    drive(1'b1, 6'd5, 5'd0);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    tick();
    flush = 1'b0;
    drive(1'b0, 6'd0, 5'd0);
    checks++; if (busy !== 1'b0 || out_ctrl !== 12'h000 || out_aluop !== 5'd0) begin
      errors++; $display("FAIL flush_clear: got busy=%b c=%h a=%h want 0 000 00", busy, out_ctrl, out_aluop);
    end
    for (int i = 0; i < LAT + 2; i++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_valid[%0d]: got %b want 0", i, out_valid); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    drive(1'b1, 6'd0, 5'd6);
    tick();
    drive(1'b0, 6'd0, 5'd0);
    tick();
    checks++; if (busy !== 1'b1 || out_ctrl !== 12'h800) begin
      errors++; $display("FAIL arst_pre: got busy=%b c=%h want 1 800", busy, out_ctrl);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || out_ctrl !== 12'h000 || out_aluop !== 5'd0 || out_illegal !== 1'b0) begin
      errors++; $display("FAIL arst_clear: got busy=%b v=%b c=%h a=%h ill=%b want all 0", busy, out_valid, out_ctrl, out_aluop, out_illegal);
    end
    #2 reset_n = 1'b1;
    drive(1'b1, 6'd3, 5'd11);
    tick();
    drive(1'b0, 6'd0, 5'd0);
    checks++; if (out_valid !== 1'b1 || out_ctrl !== 12'h830 || out_aluop !== 5'd0) begin
      errors++; $display("FAIL arst_jal: got v=%b c=%h a=%h want 1 830 00", out_valid, out_ctrl, out_aluop);
    end
    tick();
  endtask

  task automatic test_random();
    exp_t        q[$];
    exp_t        e;
    int          cyc;
    logic        md, iv, ordy, ev, er, eb;
    logic [5:0]  op;
    logic [4:0]  al;
    logic [5:0]  legal [11];
    legal = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd21, 6'd22};
    cyc = 0;
    for (int n = 0; n < 400 + LAT + 3; n++) begin
      iv   = (n < 400) && ($urandom_range(0, 9) < 7);
      ordy = (n >= 400) || ($urandom_range(0, 9) < 7);
      op   = ($urandom_range(0, 3) != 0) ? legal[$urandom_range(0, 10)] : 6'($urandom_range(0, 63));
      al   = ($urandom_range(0, 3) == 0) ? 5'(6 + $urandom_range(0, 1)) : 5'($urandom_range(0, 31));
      drive(iv, op, al);
      out_ready = ordy;
      #1;
      ev = (q.size() > 0) && (cyc >= q[0].ready);
      eb = (q.size() > 0) && (cyc < q[0].ready);
      er = (q.size() == 0) ? 1'b1 : (ev ? ordy : 1'b0);
      checks++; if (out_valid !== ev || in_ready !== er || busy !== eb) begin
        errors++; $display("FAIL rnd_hs cyc=%0d: got v=%b rdy=%b busy=%b want %b %b %b", cyc, out_valid, in_ready, busy, ev, er, eb);
      end
      if (ev) begin
        checks++; if (out_ctrl !== q[0].c || out_aluop !== q[0].a || out_illegal !== q[0].ill) begin
          errors++; $display("FAIL rnd_data cyc=%0d: got c=%h a=%h ill=%b want c=%h a=%h ill=%b",
                             cyc, out_ctrl, out_aluop, out_illegal, q[0].c, q[0].a, q[0].ill);
        end
      end
      if (ev && ordy) void'(q.pop_front());
      if (iv && er) begin
        ref_decode(op, al, e.c, e.a, e.ill, md);
        e.ready = cyc + 1 + (md ? LAT : 0);
        q.push_back(e);
      end
      tick();
      cyc++;
    end
    checks++; if (q.size() != 0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rnd_end: got pending=%0d v=%b want 0 0", q.size(), out_valid);
    end
  endtask

  initial begin
    errors = 0; checks = 0;
    reset_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 6'd0, 5'd0);
    test_reset();
    test_addi();
    test_back_to_back();
    test_decode_table();
    test_muldiv();
    test_stall();
    test_flush_md();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
